motoro3_hall_decoder: RTL and testbench

- Receive side of the 6-step commutation scheme: reads the three rotor hall sensors and recovers the commutation step (1..6) using the same numbering the commutation driver emits.
- Also recovers rotation direction, step period in clk cycles, electrical round count, stall and fault status.
- Sits between the hall input pins and the motor control logic. Closes the loop for the open-loop 6-step state machine.

---
 rtl/motoro3_hall_decoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_motoro3_hall_decoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_hall_decoder.sv
// Hall sensor decoder: recovers the 6-step commutation position, direction, step period,
// electrical revolutions, stall and fault status. Optional feature macro: MOTORO3_HALL_PERIOD6_EN.
module motoro3_hall_decoder #(
  parameter int FILT_LEN  = 8,
  parameter int PERIOD_W  = 25,
  parameter int STALL_MAX = 2_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hA,
  input  logic                hB,
  input  logic                hC,
  input  logic                clrErr,
  output logic [3:0]          m3stepHall,
  output logic                hallValid,
  output logic                dirFwd,
  output logic                stepPulse,
  output logic [PERIOD_W-1:0] m3period,
  output logic                stall,
  output logic                hallErr,
  output logic [15:0]         roundCNT,
  output logic [PERIOD_W+2:0] m3period6
);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;

  localparam logic [7:0]          FILT_LAST = 8'(FILT_LEN - 1);
  localparam logic [PERIOD_W-1:0] STALL_LIM = PERIOD_W'(STALL_MAX);
  localparam logic [PERIOD_W-1:0] P_ONE     = PERIOD_W'(1);

  function automatic logic [3:0] decode_step(input logic [2:0] code);
    case (code)
      3'b101:  decode_step = 4'd1;
      3'b100:  decode_step = 4'd2;
      3'b110:  decode_step = 4'd3;
      3'b010:  decode_step = 4'd4;
      3'b011:  decode_step = 4'd5;
      3'b001:  decode_step = 4'd6;
      default: decode_step = 4'd0;
    endcase
  endfunction

  logic [2:0]          sync1_r, sync2_r, cand_r, cand_nxt_s, filt_code_r;
  logic [7:0]          fcnt_r, fcnt_nxt_s;
  logic                filt_ok_r, load_s, acq_rst_s;
  state_t              state_r, state_nxt_s;
  logic [3:0]          code_step_s, dsum_s, delta_s, step_nxt_s;
  logic                valid_nxt_s, dir_nxt_s, pulse_nxt_s, stall_nxt_s, err_nxt_s;
  logic                fault_s, step_acc_s;
  logic [PERIOD_W-1:0] pcnt_r, pcnt_nxt_s, period_nxt_s;
  logic [15:0]         round_nxt_s;

  // Two-flop synchronizer on the raw hall pins
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= {hA, hB, hC};
      sync2_r <= sync1_r;
    end
  end

  // Candidate tracking: a code must persist FILT_LEN samples before it is accepted
  always_comb begin
    cand_nxt_s = cand_r;
    fcnt_nxt_s = fcnt_r;
    if (sync2_r != cand_r) begin
      cand_nxt_s = sync2_r;
      fcnt_nxt_s = 8'd0;
    end else if (fcnt_r != FILT_LAST) begin
      fcnt_nxt_s = fcnt_r + 8'd1;
    end else begin
      fcnt_nxt_s = fcnt_r;
    end
  end

  assign load_s = (fcnt_nxt_s == FILT_LAST);

  // Filter registers; clrErr restarts acquisition from scratch
  always_ff @(posedge clk) begin
    if (rst || acq_rst_s) begin
      cand_r      <= 3'b000;
      fcnt_r      <= 8'd0;
      filt_code_r <= 3'b000;
      filt_ok_r   <= 1'b0;
    end else begin
      cand_r <= cand_nxt_s;
      fcnt_r <= fcnt_nxt_s;
      if (load_s) begin
        filt_code_r <= cand_nxt_s;
        filt_ok_r   <= 1'b1;
      end
    end
  end

  // Step distance modulo 6: 1 = forward, 5 = reverse, anything else is a skip
  always_comb begin
    code_step_s = decode_step(filt_code_r);
    dsum_s      = code_step_s + 4'd6 - m3stepHall;
    if (dsum_s >= 4'd6) begin
      delta_s = dsum_s - 4'd6;
    end else begin
      delta_s = dsum_s;
    end
  end

  // FSM next state and next values of the registered outputs
  always_comb begin
    state_nxt_s  = state_r;
    step_nxt_s   = m3stepHall;
    valid_nxt_s  = hallValid;
    dir_nxt_s    = dirFwd;
    pulse_nxt_s  = 1'b0;
    period_nxt_s = m3period;
    pcnt_nxt_s   = pcnt_r;
    stall_nxt_s  = stall;
    err_nxt_s    = hallErr;
    round_nxt_s  = roundCNT;
    acq_rst_s    = 1'b0;
    step_acc_s   = 1'b0;
    fault_s      = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (!filt_ok_r) begin
          state_nxt_s = ST_INIT;
        end else if (code_step_s != 4'd0) begin
          state_nxt_s = ST_RUN;
          step_nxt_s  = code_step_s;
          valid_nxt_s = 1'b1;
          pcnt_nxt_s  = '0;
          stall_nxt_s = 1'b0;
        end else begin
          fault_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (pcnt_r != STALL_LIM) begin
          pcnt_nxt_s = pcnt_r + P_ONE;
        end else begin
          pcnt_nxt_s = pcnt_r;
        end
        stall_nxt_s = (pcnt_nxt_s == STALL_LIM);
        if (code_step_s == 4'd0) begin
          fault_s = 1'b1;
        end else if (code_step_s == m3stepHall) begin
          state_nxt_s = ST_RUN;
        end else if (delta_s == 4'd1 || delta_s == 4'd5) begin
          step_acc_s   = 1'b1;
          step_nxt_s   = code_step_s;
          dir_nxt_s    = (delta_s == 4'd1);
          period_nxt_s = pcnt_r;
          pcnt_nxt_s   = P_ONE;
          stall_nxt_s  = 1'b0;
          if (delta_s == 4'd1 && m3stepHall == 4'd6) begin
            round_nxt_s = roundCNT + 16'd1;
          end else if (delta_s == 4'd5 && m3stepHall == 4'd1) begin
            round_nxt_s = roundCNT - 16'd1;
          end else begin
            round_nxt_s = roundCNT;
          end
        end else begin
          fault_s = 1'b1;
        end
      end
      ST_FAULT: begin
        if (clrErr) begin
          state_nxt_s = ST_INIT;
          err_nxt_s   = 1'b0;
          acq_rst_s   = 1'b1;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
    if (fault_s) begin
      state_nxt_s = ST_FAULT;
      err_nxt_s   = 1'b1;
      valid_nxt_s = 1'b0;
      step_nxt_s  = 4'd0;
      stall_nxt_s = 1'b0;
    end else begin
      pulse_nxt_s = step_acc_s;
    end
  end

  // FSM state register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      m3stepHall <= 4'd0;
      hallValid  <= 1'b0;
      dirFwd     <= 1'b0;
      stepPulse  <= 1'b0;
      m3period   <= '0;
      pcnt_r     <= '0;
      stall      <= 1'b0;
      hallErr    <= 1'b0;
      roundCNT   <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      m3stepHall <= step_nxt_s;
      hallValid  <= valid_nxt_s;
      dirFwd     <= dir_nxt_s;
      stepPulse  <= pulse_nxt_s;
      m3period   <= period_nxt_s;
      pcnt_r     <= pcnt_nxt_s;
      stall      <= stall_nxt_s;
      hallErr    <= err_nxt_s;
      roundCNT   <= round_nxt_s;
    end
  end

`ifdef MOTORO3_HALL_PERIOD6_EN
  logic [PERIOD_W-1:0] hist_r [6];
  logic [PERIOD_W+2:0] hist_sum_s;

  // Period history, shifted on each accepted step and emptied whenever INIT is entered
  always_ff @(posedge clk) begin
    if (rst || acq_rst_s) begin
      for (int i = 0; i < 6; i++) hist_r[i] <= '0;
    end else if (step_acc_s) begin
      hist_r[0] <= pcnt_r;
      for (int i = 1; i < 6; i++) hist_r[i] <= hist_r[i-1];
    end
  end

  // Sum of the stored periods
  always_comb begin
    hist_sum_s = '0;
    for (int i = 0; i < 6; i++) hist_sum_s = hist_sum_s + (PERIOD_W+3)'(hist_r[i]);
  end

  // Registered six-step period sum
  always_ff @(posedge clk) begin
    if (rst) begin
      m3period6 <= '0;
    end else begin
      m3period6 <= hist_sum_s;
    end
  end
`else
  assign m3period6 = '0;
`endif

endmodule

// File: tb/tb_motoro3_hall_decoder.sv
// Directed bench for motoro3_hall_decoder: scoreboard of expected step transitions
// plus inline checks of latency, glitch rejection, stall and fault handling.
`timescale 1ns/1ps
module tb_motoro3_hall_decoder;
  localparam int PW = 25;
  typedef struct packed {
    logic [3:0]    step;
    logic          dir;
    logic [PW-1:0] period;
  } exp_t;

  logic clk = 1'b0;
  logic rst, hA, hB, hC, clrErr;
  logic [3:0] m3stepHall, s_step;
  logic hallValid, dirFwd, stepPulse, stall, hallErr;
  logic s_valid, s_dir, s_pulse, s_stall, s_err;
  logic [PW-1:0] m3period, s_period;
  logic [15:0] roundCNT, s_round;
  logic [PW+2:0] m3period6, s_period6;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit first_run = 1'b0;
  int n_push = 0;
  int n_pulse = 0;
  int last_period = 0;
  logic [3:0] cur_step = 4'd0;
  exp_t sb_q[$];
  exp_t mon_e;
  int hist_q[$];
  bit pend6 = 1'b0;
  logic [PW+2:0] exp6 = '0;

  motoro3_hall_decoder #(.FILT_LEN(8), .PERIOD_W(PW), .STALL_MAX(2_000_000)) dut (
    .clk(clk), .rst(rst), .hA(hA), .hB(hB), .hC(hC), .clrErr(clrErr),
    .m3stepHall(m3stepHall), .hallValid(hallValid), .dirFwd(dirFwd), .stepPulse(stepPulse),
    .m3period(m3period), .stall(stall), .hallErr(hallErr), .roundCNT(roundCNT),
    .m3period6(m3period6));

  motoro3_hall_decoder #(.FILT_LEN(8), .PERIOD_W(PW), .STALL_MAX(500)) dut_s (
    .clk(clk), .rst(rst), .hA(hA), .hB(hB), .hC(hC), .clrErr(clrErr),
    .m3stepHall(s_step), .hallValid(s_valid), .dirFwd(s_dir), .stepPulse(s_pulse),
    .m3period(s_period), .stall(s_stall), .hallErr(s_err), .roundCNT(s_round),
    .m3period6(s_period6));

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic set_hall(input logic [2:0] code);
    {hA, hB, hC} = code;
  endtask

  function automatic logic [PW+2:0] model6();
    logic [PW+2:0] s;
    s = '0;
`ifdef MOTORO3_HALL_PERIOD6_EN
    foreach (hist_q[i]) s = s + (PW+3)'(hist_q[i]);
`endif
    return s;
  endfunction

  // Called at the moment the code enabling INIT acquisition is applied
  task automatic init_entry(input logic [3:0] es, input int hold);
    last_cyc = cyc;
    first_run = 1'b1;
    tick(10);
    chk("init_wait", 32'(m3stepHall), 32'd0);
    tick(1);
    chk("init_step", 32'(m3stepHall), 32'(es));
    chk("init_valid", 32'(hallValid), 32'd1);
    chk("init_nopulse", 32'(stepPulse), 32'd0);
    cur_step = es;
    tick(hold - 11);
  endtask

  task automatic step_to(input logic [2:0] code, input logic [3:0] es, input logic ed, input int hold);
    exp_t e;
    e.step = es;
    e.dir = ed;
    e.period = PW'(cyc - last_cyc - (first_run ? 1 : 0));
    last_period = int'(e.period);
    first_run = 1'b0;
    last_cyc = cyc;
    sb_q.push_back(e);
    n_push++;
    set_hall(code);
    tick(10);
    chk("latency_hold", 32'(m3stepHall), 32'(cur_step));
    tick(1);
    chk("latency_step", 32'(m3stepHall), 32'(es));
    chk("step_dir", 32'(dirFwd), 32'(ed));
    cur_step = es;
    tick(hold - 11);
  endtask

  // Scoreboard consumer: every stepPulse must match the oldest pending transition
  always @(negedge clk) begin
    if (pend6) begin
      chk("period6", 32'(m3period6), 32'(exp6));
      pend6 = 1'b0;
    end
    if (stepPulse === 1'b1) begin
      n_pulse++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_step", 32'(m3stepHall), 32'(mon_e.step));
        chk("sb_dir", 32'(dirFwd), 32'(mon_e.dir));
        chk("sb_period", 32'(m3period), 32'(mon_e.period));
        hist_q.push_front(int'(mon_e.period));
        if (hist_q.size() > 6) void'(hist_q.pop_back());
        exp6 = model6();
        pend6 = 1'b1;
      end
    end
  end

  initial begin
    int nclr;
    rst = 1'b1;
    clrErr = 1'b0;
    set_hall(3'b101);
    tick(3);
    chk("rst_step", 32'(m3stepHall), 32'd0);
    chk("rst_valid", 32'(hallValid), 32'd0);
    chk("rst_err", 32'(hallErr), 32'd0);
    chk("rst_period", 32'(m3period), 32'd0);
    chk("rst_round", 32'(roundCNT), 32'd0);
    chk("rst_p6", 32'(m3period6), 32'd0);
    chk("rst_pulse", 32'(stepPulse), 32'd0);
    chk("rst_dir", 32'(dirFwd), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    init_entry(4'd1, 1000);

    // forward rotation
    step_to(3'b100, 4'd2, 1'b1, 1000);
    step_to(3'b110, 4'd3, 1'b1, 1000);
    step_to(3'b010, 4'd4, 1'b1, 1000);
    step_to(3'b011, 4'd5, 1'b1, 1000);
    step_to(3'b001, 4'd6, 1'b1, 1000);
    step_to(3'b101, 4'd1, 1'b1, 1000);
    chk("fwd_round", 32'(roundCNT), 32'd1);
    chk("fwd_dir", 32'(dirFwd), 32'd1);

    // reverse rotation
    step_to(3'b001, 4'd6, 1'b0, 1000);
    step_to(3'b011, 4'd5, 1'b0, 1000);
    step_to(3'b010, 4'd4, 1'b0, 1000);
    step_to(3'b110, 4'd3, 1'b0, 1000);
    step_to(3'b100, 4'd2, 1'b0, 1000);
    step_to(3'b101, 4'd1, 1'b0, 1000);
    step_to(3'b001, 4'd6, 1'b0, 1000);
    chk("rev_round", 32'(roundCNT), 32'h0000FFFF);
    chk("rev_dir", 32'(dirFwd), 32'd0);

    // glitch rejection around step 2
    step_to(3'b101, 4'd1, 1'b1, 100);
    chk("wrap_round", 32'(roundCNT), 32'd0);
    step_to(3'b100, 4'd2, 1'b1, 100);
    set_hall(3'b110);
    tick(5);
    set_hall(3'b100);
    tick(30);
    chk("glitch_step", 32'(m3stepHall), 32'd2);
    step_to(3'b110, 4'd3, 1'b1, 20);
    step_to(3'b100, 4'd2, 1'b0, 60);
    chk("pulse_dir", 32'(dirFwd), 32'd0);

    // stall on the STALL_MAX=500 instance
    step_to(3'b110, 4'd3, 1'b1, 11);
    tick(480);
    chk("stall_early", 32'(s_stall), 32'd0);
    tick(30);
    chk("stall_set", 32'(s_stall), 32'd1);
    chk("nostall_main", 32'(stall), 32'd0);
    tick(279);
    step_to(3'b010, 4'd4, 1'b1, 11);
    chk("stall_period", 32'(s_period), 32'd500);
    chk("stall_clear", 32'(s_stall), 32'd0);
    tick(100);

    // invalid code fault
    set_hall(3'b111);
    tick(10);
    chk("fault_wait", 32'(hallErr), 32'd0);
    tick(1);
    chk("fault_err", 32'(hallErr), 32'd1);
    chk("fault_step", 32'(m3stepHall), 32'd0);
    chk("fault_valid", 32'(hallValid), 32'd0);
    chk("fault_period", 32'(m3period), 32'(last_period));
    cur_step = 4'd0;
    tick(5);
    clrErr = 1'b1;
    hist_q.delete();
    tick(1);
    clrErr = 1'b0;
    chk("clr_err", 32'(hallErr), 32'd0);
    tick(8);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    chk("clr_vs_fault", 32'(hallErr), 32'd1);
    tick(5);
    chk("fault_sticky", 32'(hallErr), 32'd1);

    // recovery: valid code then clrErr
    set_hall(3'b101);
    tick(20);
    clrErr = 1'b1;
    nclr = cyc;
    hist_q.delete();
    tick(1);
    clrErr = 1'b0;
    chk("recover_err", 32'(hallErr), 32'd0);
    tick(8);
    chk("recover_wait", 32'(m3stepHall), 32'd0);
    tick(1);
    chk("recover_step", 32'(m3stepHall), 32'd1);
    chk("recover_valid", 32'(hallValid), 32'd1);
    last_cyc = nclr - 1;
    first_run = 1'b1;
    cur_step = 4'd1;
    tick(50);

    // skipped step 1 -> 3
    set_hall(3'b110);
    tick(11);
    chk("skip_err", 32'(hallErr), 32'd1);
    chk("skip_step", 32'(m3stepHall), 32'd0);

    // mid-operation reset
    rst = 1'b1;
    hist_q.delete();
    tick(1);
    chk("mrst_err", 32'(hallErr), 32'd0);
    chk("mrst_period", 32'(m3period), 32'd0);
    chk("mrst_valid", 32'(hallValid), 32'd0);
    set_hall(3'b101);
    tick(2);
    rst = 1'b0;

    // six distinct periods 100..600
    init_entry(4'd1, 101);
    step_to(3'b100, 4'd2, 1'b1, 200);
    step_to(3'b110, 4'd3, 1'b1, 300);
    step_to(3'b010, 4'd4, 1'b1, 400);
    step_to(3'b011, 4'd5, 1'b1, 500);
    step_to(3'b001, 4'd6, 1'b1, 600);
    step_to(3'b101, 4'd1, 1'b1, 11);
    tick(1);
`ifdef MOTORO3_HALL_PERIOD6_EN
    chk("period6_total", 32'(m3period6), 32'd2100);
`else
    chk("period6_total", 32'(m3period6), 32'd0);
`endif
    chk("p6_round", 32'(roundCNT), 32'd1);
    tick(20);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("pulse_count", 32'(n_pulse), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
